// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex glyph table.
// Segment order is {a,b,c,d,e,f,g}, active-high, bit 6 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'h7E;
      4'h1: s = 7'h30;
      4'h2: s = 7'h6D;
      4'h3: s = 7'h79;
      4'h4: s = 7'h33;
      4'h5: s = 7'h5B;
      4'h6: s = 7'h5F;
      4'h7: s = 7'h70;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h73;
      4'hA: s = 7'h77;
      4'hB: s = 7'h1F;
      4'hC: s = 7'h4E;
      4'hD: s = 7'h3D;
      4'hE: s = 7'h4F;
      4'hF: s = 7'h47;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble -> active-high 7-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nib);

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: double-buffered nibbles, leading-zero blanking,
// anti-ghost dark cycle at the start of every digit slot.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int CLK_DIV        = 1000,
  parameter int ACTIVE_LOW_SEG = 0,
  parameter int ACTIVE_LOW_DIG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_sel,
  output logic                  frame_done
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0]     PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_INV  = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic              DP_INV   = (ACTIVE_LOW_SEG != 0);
  localparam logic [DIGITS-1:0] DIG_INV  = (ACTIVE_LOW_DIG != 0) ? '1 : '0;

  logic [PW-1:0]            pre;
  logic [IW-1:0]            idx;
  logic [DIGITS-1:0][3:0]   pend_nib, disp_nib;
  logic [DIGITS-1:0]        pend_dp, disp_dp;
  logic [DIGITS-1:0]        lz;
  logic [DIGITS-1:0]        onehot;
  logic                     wrap, blank, first;
  logic [3:0]               cur_nib;
  logic [6:0]               dec_seg;

  assign wrap    = en && (pre == PRE_LAST) && (idx == IDX_LAST);
  assign first   = (pre == '0);
  assign onehot  = DIGITS'(1) << idx;
  assign cur_nib = disp_nib[idx];
  assign blank   = blank_lz && lz[idx];

  seg7_hex_decode u_dec (
    .nib (cur_nib),
    .seg (dec_seg)
  );

  // lz[k]: nibbles DIGITS-1..k are all zero; digit 0 always shows
  always_comb begin
    logic run;
    run = 1'b1;
    lz  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run   = run && (disp_nib[k] == 4'h0);
      lz[k] = run;
    end
    lz[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else if (en) begin
      if (pre == PRE_LAST) begin
        pre <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        pre <= pre + 1'b1;
      end
    end
  end

  // Display only changes at the frame boundary, so a frame never mixes old and new data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_nib <= '0;
      pend_dp  <= '0;
      disp_nib <= '0;
      disp_dp  <= '0;
    end else begin
      if (load) begin
        pend_nib <= data;
        pend_dp  <= dp_in;
      end
      if (wrap) begin
        disp_nib <= load ? data  : pend_nib;
        disp_dp  <= load ? dp_in : pend_dp;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      segments   <= SEG_INV;
      dp         <= DP_INV;
      digit_sel  <= DIG_INV;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (en) begin
        segments  <= (blank ? SEG_BLANK : dec_seg) ^ SEG_INV;
        dp        <= (disp_dp[idx] && !first) ^ DP_INV;
        digit_sel <= (first ? '0 : onehot) ^ DIG_INV;
      end else begin
        segments  <= SEG_INV;
        dp        <= DP_INV;
        digit_sel <= DIG_INV;
      end
    end
  end

endmodule
